// File: rtl/softmax_pkg.sv
// Purpose : shared types, defaults and fp16 helpers for the softmax result streamer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package softmax_pkg;

    localparam int N_ELEM_DEF = 10;
    localparam int DATA_W_DEF = 16;
    localparam int IDX_W_DEF  = 4;
    // Latency counter width; covers PIPE_LAT up to 255.
    localparam int LAT_W      = 8;

    localparam logic [4:0] FP16_EXP_ALL1 = 5'h1F;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STREAM
    } state_e;

    // Quiet or signalling NaN: all-ones exponent with non-zero mantissa.
    function automatic logic fp16_is_nan(input logic [15:0] x);
        return (x[14:10] == FP16_EXP_ALL1) && (x[9:0] != 10'd0);
    endfunction

endpackage

// File: rtl/softmax_fp16_max_cmp.sv
// Purpose : decides whether an fp16 candidate replaces the current argmax best.
// Latency : combinational.
// Backpressure: none.
// Ports: cand - candidate element; best - current best value (always a
//        qualifying value or zero); take - candidate strictly beats best.
module softmax_fp16_max_cmp
    import softmax_pkg::*;
(
    input  logic [15:0] cand,
    input  logic [15:0] best,
    output logic        take
);

    // Only non-negative, non-NaN values compete. For those, the magnitude
    // bits order exactly like the fp16 values, so an unsigned compare works.
    // Strict '>' keeps the lower index on ties.
    assign take = !cand[15] && !fp16_is_nan(cand) && (cand[14:0] > best[14:0]);

endmodule

// File: rtl/softmax_result_streamer.sv
// Purpose : waits PIPE_LAT cycles after start, captures N_ELEM fp16 results, streams them on AXI4-Stream, reports argmax.
// Latency : capture at edge PIPE_LAT after start; first beat valid after that edge; PIPE_LAT+N_ELEM cycles to last beat at tready=1.
// Backpressure: tdata/tuser/tlast hold while tvalid && !tready; a start while busy is dropped and sets sticky overrun.
//
// Ports: aclk/aresetn clock and async active-low reset; start strobe; res_in packed
//        results (element i at [i*DATA_W +: DATA_W]); m_axis_* stream master;
//        busy (WAIT or STREAM); overrun (sticky dropped start); argmax_idx/argmax_valid.
// Build option: define SOFTMAX_ARGMAX_EN to build the argmax tracker; otherwise
//        argmax_idx and argmax_valid are tied low.
module softmax_result_streamer
    import softmax_pkg::*;
#(
    parameter int N_ELEM   = N_ELEM_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int PIPE_LAT = 40
)
(
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     start,
    input  logic [N_ELEM*DATA_W-1:0] res_in,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [IDX_W-1:0]         m_axis_tuser,
    output logic                     m_axis_tlast,
    output logic                     busy,
    output logic                     overrun,
    output logic [IDX_W-1:0]         argmax_idx,
    output logic                     argmax_valid
);

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   lat_cnt_q;
    logic [IDX_W-1:0]   elem_cnt_q;
    logic [DATA_W-1:0]  buf_q [N_ELEM];
    logic               overrun_q;
    logic               load, capture, beat, last_beat;

    assign m_axis_tvalid = (state_q == STREAM);
    assign m_axis_tlast  = m_axis_tvalid && (elem_cnt_q == IDX_W'(N_ELEM - 1));
    assign m_axis_tdata  = m_axis_tvalid ? buf_q[elem_cnt_q] : '0;
    assign m_axis_tuser  = m_axis_tvalid ? elem_cnt_q : '0;
    assign beat          = m_axis_tvalid && m_axis_tready;
    assign last_beat     = beat && m_axis_tlast;
    assign busy          = (state_q != IDLE);
    assign overrun       = overrun_q;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // A start coinciding with the final handshake chains straight
                // into the next vector without an idle cycle.
                if (last_beat) begin
                    if (start) begin
                        load    = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            lat_cnt_q  <= '0;
            elem_cnt_q <= '0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < N_ELEM; i++) buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                lat_cnt_q <= LAT_W'(PIPE_LAT - 1);
            end else if (state_q == WAIT && lat_cnt_q != '0) begin
                lat_cnt_q <= lat_cnt_q - 1'b1;
            end
            if (capture) begin
                for (int i = 0; i < N_ELEM; i++) buf_q[i] <= res_in[i*DATA_W +: DATA_W];
                elem_cnt_q <= '0;
            end else if (beat && !last_beat) begin
                elem_cnt_q <= elem_cnt_q + 1'b1;
            end
            if (start && busy && !last_beat) overrun_q <= 1'b1;
        end
    end

`ifdef SOFTMAX_ARGMAX_EN
    // Running maximum, evaluated on each element as it transfers; the final
    // element's verdict is folded in directly when publishing the result.
    logic [DATA_W-1:0] best_val_q;
    logic [IDX_W-1:0]  best_idx_q;
    logic [IDX_W-1:0]  argmax_idx_q;
    logic              argmax_valid_q;
    logic              take;

    softmax_fp16_max_cmp u_cmp (
        .cand (m_axis_tdata),
        .best (best_val_q),
        .take (take)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            best_val_q     <= '0;
            best_idx_q     <= '0;
            argmax_idx_q   <= '0;
            argmax_valid_q <= 1'b0;
        end else begin
            argmax_valid_q <= 1'b0;
            if (capture) begin
                // Zero baseline: no qualifying element leaves index 0.
                best_val_q <= '0;
                best_idx_q <= '0;
            end else if (beat) begin
                if (take) begin
                    best_val_q <= m_axis_tdata;
                    best_idx_q <= elem_cnt_q;
                end
                if (last_beat) begin
                    argmax_idx_q   <= take ? elem_cnt_q : best_idx_q;
                    argmax_valid_q <= 1'b1;
                end
            end
        end
    end

    assign argmax_idx   = argmax_idx_q;
    assign argmax_valid = argmax_valid_q;
`else
    assign argmax_idx   = '0;
    assign argmax_valid = 1'b0;
`endif

endmodule

// File: tb/tb_softmax_result_streamer.sv
// Purpose : randomized self-checking bench for softmax_result_streamer against a vector-level model.
// Latency : n/a.
// Backpressure: bench drives tready patterns (constant, 1-0-0-1, random).
module tb_softmax_result_streamer;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int IW = 4;
    localparam int PL = 4;

    logic              aclk;
    logic              aresetn;
    logic              start;
    logic [N*DW-1:0]   res_in;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [IW-1:0]     m_axis_tuser;
    logic              m_axis_tlast;
    logic              busy;
    logic              overrun;
    logic [IW-1:0]     argmax_idx;
    logic              argmax_valid;

    softmax_result_streamer #(
        .N_ELEM   (N),
        .DATA_W   (DW),
        .IDX_W    (IW),
        .PIPE_LAT (PL)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start),
        .res_in        (res_in),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .overrun       (overrun),
        .argmax_idx    (argmax_idx),
        .argmax_valid  (argmax_valid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;

    // Vector-level model state.
    int          cyc      = 0;
    int          cap_edge = -1000;
    bit          m_busy   = 0;
    bit          m_ovr    = 0;
    bit          m_av     = 0;
    logic [3:0]  m_ai     = '0;
    int          m_bi     = 0;
    logic [15:0] cur_vec [N];
    logic [15:0] nxt_vec [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Largest non-negative, non-NaN element by value; earliest wins ties; 0 if none.
    function automatic logic [3:0] ref_argmax();
        int          best = 0;
        logic [14:0] bv   = '0;
        for (int i = 0; i < N; i++) begin
            logic [15:0] v;
            v = cur_vec[i];
            if (!v[15] && !(v[14:10] == 5'h1F && v[9:0] != 0) && v[14:0] > bv) begin
                bv   = v[14:0];
                best = i;
            end
        end
        return 4'(best);
    endfunction

    function automatic logic [15:0] rand_fp16();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 7))
            0:       r = {r[15], 5'h1F, (r[9:0] == 0) ? 10'h200 : r[9:0]};
            1:       r[15] = 1'b1;
            2:       r = 16'h3C00;
            default: r[15] = 1'b0;
        endcase
        return r;
    endfunction

    // One clock: sample and check outputs, then drive inputs for the next edge
    // and advance the model by what that edge will do.
    task automatic step(input bit st, input bit rdy);
        bit exp_vld, hs, lastb, acc, was_busy;
        @(negedge aclk);
        exp_vld = m_busy && (cyc > cap_edge);
        check("tvalid", 32'(m_axis_tvalid), 32'(exp_vld));
        check("busy", 32'(busy), 32'(m_busy));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("argmax_valid", 32'(argmax_valid), 32'(m_av));
        check("argmax_idx", 32'(argmax_idx), 32'(m_ai));
        if (exp_vld) begin
            check("tdata", 32'(m_axis_tdata), 32'(cur_vec[m_bi]));
            check("tuser", 32'(m_axis_tuser), 32'(m_bi));
            check("tlast", 32'(m_axis_tlast), 32'(m_bi == N - 1));
        end

        start         = st;
        m_axis_tready = rdy;
        was_busy = m_busy;
        hs       = exp_vld && rdy;
        lastb    = hs && (m_bi == N - 1);
        m_av     = 1'b0;
        if (lastb) begin
`ifdef SOFTMAX_ARGMAX_EN
            m_av = 1'b1;
            m_ai = ref_argmax();
`endif
            m_busy = 1'b0;
        end
        if (hs && !lastb) m_bi++;
        acc = st && (!was_busy || lastb);
        if (st && !acc) m_ovr = 1'b1;
        if (acc) begin
            for (int i = 0; i < N; i++) cur_vec[i] = nxt_vec[i];
            m_busy   = 1'b1;
            cap_edge = cyc + PL;
            m_bi     = 0;
        end
        // Results are only valid on the exact capture edge; garbage elsewhere.
        for (int i = 0; i < N; i++)
            res_in[i*DW +: DW] = (m_busy && cyc == cap_edge) ? cur_vec[i] : 16'($urandom);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    task automatic fill_const(input logic [15:0] v);
        for (int i = 0; i < N; i++) nxt_vec[i] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) nxt_vec[i] = rand_fp16();
    endtask

    initial begin
        bit reached;
        aresetn       = 1'b0;
        start         = 1'b0;
        m_axis_tready = 1'b0;
        res_in        = '0;
        fill_const(16'h0000);
        for (int i = 0; i < N; i++) cur_vec[i] = '0;

        // Reset state.
        repeat (2) @(negedge aclk);
        check("rst_tvalid", 32'(m_axis_tvalid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_tdata", 32'(m_axis_tdata), 0);
        check("rst_tuser", 32'(m_axis_tuser), 0);
        check("rst_tlast", 32'(m_axis_tlast), 0);
        check("rst_argmax_idx", 32'(argmax_idx), 0);
        check("rst_argmax_valid", 32'(argmax_valid), 0);
        @(posedge aclk);
        #2 aresetn = 1'b1;

        // Basic vector, tready held high.
        fill_const(16'h2000);
        nxt_vec[3] = 16'h2E66;
        step(1'b1, 1'b1);
        idle(20);

        // Backpressure 1,0,0,1 repeating.
        fill_rand();
        step(1'b1, 1'b1);
        for (int i = 1; i < 50; i++) step(1'b0, (i % 4 == 0) || (i % 4 == 3));
        idle(4);

        // Start two cycles into WAIT is dropped and sets overrun.
        fill_rand();
        step(1'b1, 1'b1);
        idle(2);
        fill_const(16'h7777);
        step(1'b1, 1'b1);
        idle(20);

        // Start on the final handshake chains the next vector.
        fill_rand();
        step(1'b1, 1'b1);
        reached = 0;
        for (int g = 0; g < 200 && !reached; g++) begin
            if (m_busy && cyc > cap_edge && m_bi == N - 1) reached = 1;
            else step(1'b0, 1'b1);
        end
        check("tlast_reached", 32'(reached), 1);
        fill_rand();
        step(1'b1, 1'b1);
        idle(20);

        // Argmax corner cases.
        fill_const(16'h3C00);
        step(1'b1, 1'b1);
        idle(20);
        fill_const(16'h0001);
        nxt_vec[1] = 16'h7E00;
        nxt_vec[2] = 16'hBC00;
        step(1'b1, 1'b1);
        idle(20);
        fill_const(16'h7E00);
        step(1'b1, 1'b1);
        idle(20);

        // Random starts, data and backpressure.
        for (int i = 0; i < 600; i++) begin
            fill_rand();
            step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
        end
        idle(30);

        // Reset in the middle of streaming, after beat 4.
        fill_rand();
        step(1'b1, 1'b1);
        reached = 0;
        for (int g = 0; g < 200 && !reached; g++) begin
            if (m_busy && cyc > cap_edge && m_bi == 5) reached = 1;
            else step(1'b0, 1'b1);
        end
        check("beat4_reached", 32'(reached), 1);
        check("pre_rst_overrun", 32'(overrun), 32'(m_ovr));
        @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        check("arst_tvalid", 32'(m_axis_tvalid), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_overrun", 32'(overrun), 0);
        check("arst_tlast", 32'(m_axis_tlast), 0);
        @(posedge aclk);
        @(posedge aclk);
        #2 aresetn = 1'b1;
        m_busy = 0; m_ovr = 0; m_av = 0; m_ai = '0; m_bi = 0; cap_edge = -1000;
        idle(12);

        // Recovery with a fresh vector.
        fill_rand();
        step(1'b1, 1'b1);
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
